// File: rtl/ucsbece154b_victim_cache_pipelined_if.sv
// Lookup/response and insert bus between the L1 and the victim cache.
// The master (L1 side) issues lookups and evictions; the slave (cache) answers one cycle later.
interface ucsbece154b_victim_cache_pipelined_if #(
    parameter int ADDR_WIDTH = 56,
    parameter int LINE_WIDTH = 128
);
    logic                  req_valid_i;
    logic [ADDR_WIDTH-1:0] raddr_i;
    logic                  rsp_valid_o;
    logic                  hit_o;
    logic [LINE_WIDTH-1:0] rdata_o;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] waddr_i;
    logic [LINE_WIDTH-1:0] wdata_i;

    modport master (
        output req_valid_i, raddr_i, we_i, waddr_i, wdata_i,
        input  rsp_valid_o, hit_o, rdata_o
    );

    modport slave (
        input  req_valid_i, raddr_i, we_i, waddr_i, wdata_i,
        output rsp_valid_o, hit_o, rdata_o
    );
endinterface

// File: rtl/ucsbece154b_victim_cache_pipelined.sv
// Fully-associative victim cache with age-counter LRU, 1-cycle pipelined lookups,
// optional swap-on-hit invalidation and saturating hit/miss statistics.
module ucsbece154b_victim_cache_pipelined #(
    parameter int ADDR_WIDTH  = 56,
    parameter int LINE_WIDTH  = 128,
    parameter int NR_ENTRIES  = 4,
    parameter int SWAP_ON_HIT = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 en_i,
    ucsbece154b_victim_cache_pipelined_if.slave bus,
    input  logic                 clr_stats_i,
    output logic [CNT_WIDTH-1:0] hit_count_o,
    output logic [CNT_WIDTH-1:0] miss_count_o
);
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int TAG_W  = ADDR_WIDTH - OFFSET;
    localparam int AW     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam logic [AW-1:0] AGE_LRU = AW'(NR_ENTRIES - 1);

    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [AW-1:0]         age_t;

    logic  valid_r [NR_ENTRIES];
    tag_t  tag_r   [NR_ENTRIES];
    line_t data_r  [NR_ENTRIES];
    age_t  age_r   [NR_ENTRIES];

    logic  valid_a_s [NR_ENTRIES];
    age_t  age_a_s   [NR_ENTRIES];
    logic  valid_n_s [NR_ENTRIES];
    age_t  age_n_s   [NR_ENTRIES];

    logic [NR_ENTRIES-1:0] rmatch_s;
    tag_t  rtag_s, wtag_s;
    logic  active_s, rd_s, wr_s;
    logic  hit_s;
    age_t  hit_idx_s, hit_age_s;
    line_t hit_data_s;
    logic  wmatch_s, winv_s;
    age_t  widx_match_s, widx_inv_s, widx_lru_s;
    age_t  tgt_s, tgt_age_s;
    logic  addr_unused_s;

    logic                 rsp_valid_r, hit_r;
    line_t                rdata_r;
    logic [CNT_WIDTH-1:0] hit_cnt_r, miss_cnt_r;

    assign rtag_s        = bus.raddr_i[ADDR_WIDTH-1:OFFSET];
    assign wtag_s        = bus.waddr_i[ADDR_WIDTH-1:OFFSET];
    assign addr_unused_s = ^{bus.raddr_i, bus.waddr_i};
    // A disabled or flushing cache ignores both ports for the cycle.
    assign active_s      = en_i & ~flush_i;
    assign rd_s          = active_s & bus.req_valid_i;
    assign wr_s          = active_s & bus.we_i;

    // Lookup against the pre-edge contents; tags are unique so matches can be OR-combined.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        hit_age_s  = '0;
        hit_data_s = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            rmatch_s[i] = valid_r[i] && (tag_r[i] == rtag_s);
            hit_s       = hit_s | rmatch_s[i];
            hit_idx_s   = hit_idx_s  | (rmatch_s[i] ? AW'(i)    : '0);
            hit_age_s   = hit_age_s  | (rmatch_s[i] ? age_r[i]  : '0);
            hit_data_s  = hit_data_s | (rmatch_s[i] ? data_r[i] : '0);
        end
    end

    // State after the read side effect: bump the hit way and optionally swap it out.
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (rd_s && hit_s && (AW'(i) == hit_idx_s)) begin
                valid_a_s[i] = (SWAP_ON_HIT == 0) ? 1'b1 : 1'b0;
                age_a_s[i]   = '0;
            end else if (rd_s && hit_s && (age_r[i] < hit_age_s)) begin
                valid_a_s[i] = valid_r[i];
                age_a_s[i]   = age_r[i] + AW'(1);
            end else begin
                valid_a_s[i] = valid_r[i];
                age_a_s[i]   = age_r[i];
            end
        end
    end

    // Write target: resident tag, else lowest invalid way, else the oldest way.
    always_comb begin
        wmatch_s     = 1'b0;
        winv_s       = 1'b0;
        widx_match_s = '0;
        widx_inv_s   = '0;
        widx_lru_s   = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            wmatch_s     = wmatch_s | (valid_a_s[i] && (tag_r[i] == wtag_s));
            widx_match_s = (valid_a_s[i] && (tag_r[i] == wtag_s)) ? AW'(i) : widx_match_s;
            winv_s       = winv_s | ~valid_a_s[i];
            widx_inv_s   = (!valid_a_s[i]) ? AW'(i) : widx_inv_s;
            widx_lru_s   = (age_a_s[i] == AGE_LRU) ? AW'(i) : widx_lru_s;
        end
        tgt_s     = wmatch_s ? widx_match_s : (winv_s ? widx_inv_s : widx_lru_s);
        tgt_age_s = age_a_s[tgt_s];
    end

    // Apply the write on top of the read result so the written line ends up MRU.
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (wr_s && (AW'(i) == tgt_s)) begin
                valid_n_s[i] = 1'b1;
                age_n_s[i]   = '0;
            end else if (wr_s && (age_a_s[i] < tgt_age_s)) begin
                valid_n_s[i] = valid_a_s[i];
                age_n_s[i]   = age_a_s[i] + AW'(1);
            end else begin
                valid_n_s[i] = valid_a_s[i];
                age_n_s[i]   = age_a_s[i];
            end
        end
    end

    // Way storage; flush/disable drops all lines and restores the identity age order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                age_r[i]   <= AW'(i);
                tag_r[i]   <= '0;
                data_r[i]  <= '0;
            end
        end else if (!active_s) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                age_r[i]   <= AW'(i);
            end
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_r[i] <= valid_n_s[i];
                age_r[i]   <= age_n_s[i];
                if (wr_s && (AW'(i) == tgt_s)) begin
                    tag_r[i]  <= wtag_s;
                    data_r[i] <= bus.wdata_i;
                end
            end
        end
    end

    // Response stage; rdata holds across idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            hit_r       <= 1'b0;
            rdata_r     <= '0;
        end else begin
            rsp_valid_r <= rd_s;
            hit_r       <= rd_s & hit_s;
            if (rd_s) begin
                rdata_r <= hit_s ? hit_data_s : '0;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else if (clr_stats_i) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else if (rd_s && hit_s && (hit_cnt_r != '1)) begin
            hit_cnt_r  <= hit_cnt_r + CNT_WIDTH'(1);
        end else if (rd_s && !hit_s && (miss_cnt_r != '1)) begin
            miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
        end
    end

    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.hit_o       = hit_r;
    assign bus.rdata_o     = rdata_r;
    assign hit_count_o     = hit_cnt_r;
    assign miss_count_o    = miss_cnt_r;
endmodule

// File: tb/tb_ucsbece154b_victim_cache_pipelined.sv
// Directed bench: dut0 is swap-on-hit with 32-bit counters, dut1 keeps lines on hit with
// 2-bit counters; both see identical stimulus and are checked against hand-derived values.
module tb_ucsbece154b_victim_cache_pipelined;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         en = 1'b1;
    logic         clr = 1'b0;
    logic         req = 1'b0;
    logic [55:0]  raddr = '0;
    logic         we = 1'b0;
    logic [55:0]  waddr = '0;
    logic [127:0] wdata = '0;
    logic [31:0]  hc0, mc0;
    logic [1:0]   hc1, mc1;
    logic [127:0] ones = '1;

    int checks = 0;
    int errors = 0;
    int e_h0 = 0, e_m0 = 0, e_h1 = 0, e_m1 = 0;

    localparam logic [51:0] TA = 52'h100, TB = 52'h200, TC = 52'h300;
    localparam logic [51:0] TD = 52'h400, TE = 52'h500, TF = 52'h600;

    always #5 clk = ~clk;

    ucsbece154b_victim_cache_pipelined_if #(.ADDR_WIDTH(56), .LINE_WIDTH(128)) bus0 ();
    ucsbece154b_victim_cache_pipelined_if #(.ADDR_WIDTH(56), .LINE_WIDTH(128)) bus1 ();

    assign bus0.req_valid_i = req;
    assign bus0.raddr_i     = raddr;
    assign bus0.we_i        = we;
    assign bus0.waddr_i     = waddr;
    assign bus0.wdata_i     = wdata;
    assign bus1.req_valid_i = req;
    assign bus1.raddr_i     = raddr;
    assign bus1.we_i        = we;
    assign bus1.waddr_i     = waddr;
    assign bus1.wdata_i     = wdata;

    ucsbece154b_victim_cache_pipelined #(.SWAP_ON_HIT(1), .CNT_WIDTH(32)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .en_i(en), .bus(bus0),
        .clr_stats_i(clr), .hit_count_o(hc0), .miss_count_o(mc0)
    );

    ucsbece154b_victim_cache_pipelined #(.SWAP_ON_HIT(0), .CNT_WIDTH(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .en_i(en), .bus(bus1),
        .clr_stats_i(clr), .hit_count_o(hc1), .miss_count_o(mc1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] dat(input logic [51:0] t);
        logic [31:0] w;
        w = t[31:0];
        return {w ^ 32'hA5A5_0000, w, ~w, w + 32'd7};
    endfunction

    function automatic logic [55:0] adr(input logic [51:0] t);
        return {t, 4'h0};
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [51:0] t, input logic [127:0] d);
        we = 1'b1; waddr = adr(t); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic fill();
        wr(TA, dat(TA)); wr(TB, dat(TB)); wr(TC, dat(TC)); wr(TD, dat(TD));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [55:0] a, input bit h0, input bit h1,
                      input logic [127:0] d, input bit do_w = 1'b0,
                      input logic [51:0] wt = '0, input logic [127:0] wd = '0);
        req = 1'b1; raddr = a;
        if (do_w) begin
            we = 1'b1; waddr = adr(wt); wdata = wd;
        end
        tick();
        req = 1'b0; we = 1'b0;
        check({nm, "_rv0"},  {127'd0, bus0.rsp_valid_o}, 128'd1);
        check({nm, "_hit0"}, {127'd0, bus0.hit_o}, {127'd0, h0});
        check({nm, "_dat0"}, bus0.rdata_o, h0 ? d : 128'd0);
        check({nm, "_rv1"},  {127'd0, bus1.rsp_valid_o}, 128'd1);
        check({nm, "_hit1"}, {127'd0, bus1.hit_o}, {127'd0, h1});
        check({nm, "_dat1"}, bus1.rdata_o, h1 ? d : 128'd0);
        if (h0) e_h0++; else e_m0++;
        if (h1) e_h1++; else e_m1++;
    endtask

    task automatic cnt(input string nm);
        check({nm, "_hc0"}, 128'(hc0), 128'(e_h0));
        check({nm, "_mc0"}, 128'(mc0), 128'(e_m0));
        check({nm, "_hc1"}, 128'(hc1), 128'(sat3(e_h1)));
        check({nm, "_mc1"}, 128'(mc1), 128'(sat3(e_m1)));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_rv0", {127'd0, bus0.rsp_valid_o}, 128'd0);
        check("rst_hit0", {127'd0, bus0.hit_o}, 128'd0);
        check("rst_dat0", bus0.rdata_o, 128'd0);
        check("rst_rv1", {127'd0, bus1.rsp_valid_o}, 128'd0);
        cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: swap-on-hit removes the line after the first hit; offset bits ignored
        fill();
        rd("t1_b", 56'h2008, 1'b1, 1'b1, dat(TB));
        rd("t1_b2", 56'h2000, 1'b0, 1'b1, dat(TB));
        check("t1_hc0", 128'(hc0), 128'd1);
        check("t1_mc0", 128'(mc0), 128'd1);
        cnt("t1");
        tick();
        check("t1_idle_rv0", {127'd0, bus0.rsp_valid_o}, 128'd0);
        check("t1_idle_hit1", {127'd0, bus1.hit_o}, 128'd0);
        check("t1_idle_hold1", bus1.rdata_o, dat(TB));

        // 2: LRU eviction (dut1) vs refill of the swapped-out way (dut0)
        do_flush();
        fill();
        rd("t2_a", adr(TA), 1'b1, 1'b1, dat(TA));
        wr(TE, dat(TE));
        rd("t2_b", adr(TB), 1'b1, 1'b0, dat(TB));
        rd("t2_a2", adr(TA), 1'b0, 1'b1, dat(TA));
        rd("t2_e", adr(TE), 1'b1, 1'b1, dat(TE));
        cnt("t2");

        // 3: update in place keeps a single copy of A
        do_flush();
        wr(TA, dat(TA)); wr(TB, dat(TB)); wr(TA, ones);
        rd("t3_a", adr(TA), 1'b1, 1'b1, ones);
        wr(TC, dat(TC)); wr(TD, dat(TD));
        rd("t3_a2", adr(TA), 1'b0, 1'b1, ones);
        rd("t3_b", adr(TB), 1'b1, 1'b1, dat(TB));
        rd("t3_c", adr(TC), 1'b1, 1'b1, dat(TC));
        rd("t3_d", adr(TD), 1'b1, 1'b1, dat(TD));

        // 4: same-cycle read hit and write while full
        do_flush();
        fill();
        rd("t4_rw", adr(TA), 1'b1, 1'b1, dat(TA), 1'b1, TF, dat(TF));
        rd("t4_b", adr(TB), 1'b1, 1'b0, dat(TB));
        rd("t4_c", adr(TC), 1'b1, 1'b1, dat(TC));
        rd("t4_d", adr(TD), 1'b1, 1'b1, dat(TD));
        rd("t4_f", adr(TF), 1'b1, 1'b1, dat(TF));
        rd("t4_a", adr(TA), 1'b0, 1'b1, dat(TA));
        cnt("t4");

        // 5: a request during flush is dropped; later lookups miss; clear stats
        flush = 1'b1; req = 1'b1; raddr = adr(TC);
        tick();
        flush = 1'b0; req = 1'b0;
        check("t5_rv0", {127'd0, bus0.rsp_valid_o}, 128'd0);
        check("t5_rv1", {127'd0, bus1.rsp_valid_o}, 128'd0);
        check("t5_hit1", {127'd0, bus1.hit_o}, 128'd0);
        cnt("t5_fl");
        rd("t5_c", adr(TC), 1'b0, 1'b0, 128'd0);
        rd("t5_f", adr(TF), 1'b0, 1'b0, 128'd0);
        cnt("t5");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        e_h0 = 0; e_m0 = 0; e_h1 = 0; e_m1 = 0;
        cnt("t5_clr");

        // 6: saturation of the 2-bit counter, then async reset mid-stream
        for (int k = 0; k < 5; k++) begin
            rd("t6_miss", adr(52'h700 + 52'(k)), 1'b0, 1'b0, 128'd0);
        end
        check("t6_mc1_sat", 128'(mc1), 128'd3);
        check("t6_mc0", 128'(mc0), 128'd5);
        wr(TA, dat(TA));
        req = 1'b1; raddr = adr(TA);
        tick();
        check("t6_hit0", {127'd0, bus0.hit_o}, 128'd1);
        check("t6_hc0", 128'(hc0), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rv0", {127'd0, bus0.rsp_valid_o}, 128'd0);
        check("t6_rst_hit0", {127'd0, bus0.hit_o}, 128'd0);
        check("t6_rst_rv1", {127'd0, bus1.rsp_valid_o}, 128'd0);
        e_h0 = 0; e_m0 = 0; e_h1 = 0; e_m1 = 0;
        cnt("t6_rst");
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_rel_rv0", {127'd0, bus0.rsp_valid_o}, 128'd0);
        check("t6_rel_rv1", {127'd0, bus1.rsp_valid_o}, 128'd0);
        rd("t6_a", adr(TA), 1'b0, 1'b0, 128'd0);
        cnt("t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
